// File: rtl/smc_mem_mapper.sv
// SMC-777 memory/IO mapper: four 16 KB page registers, IO decode, memory wait states,
// ioctl download path and CPU reset hold. Define WRITE_PROT_EN to block CPU writes to ROM pages.
module smc_mem_mapper #(
  parameter int PAGE_W    = 4,
  parameter int IO_DEVS   = 8,
  parameter int MEM_WAIT  = 1,
  parameter int RST_HOLD  = 16,
  parameter int DL_INDEX  = 0,
  parameter int ROM_PAGES = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [15:0]            cpu_addr,
  input  logic [7:0]             cpu_dout,
  output logic [7:0]             cpu_din,
  input  logic                   cpu_mreq_n,
  input  logic                   cpu_iorq_n,
  input  logic                   cpu_rd_n,
  input  logic                   cpu_wr_n,
  input  logic                   cpu_m1_n,
  output logic                   cpu_wait_n,
  output logic                   cpu_reset,
  input  logic                   ioctl_download,
  input  logic [7:0]             ioctl_index,
  input  logic                   ioctl_wr,
  input  logic [24:0]            ioctl_addr,
  input  logic [7:0]             ioctl_dout,
  output logic [PAGE_W+13:0]     mem_addr,
  output logic [7:0]             mem_wdata,
  output logic                   mem_we,
  input  logic [7:0]             mem_rdata,
  output logic [IO_DEVS-1:0]     io_sel,
  input  logic [8*IO_DEVS-1:0]   io_rdata
);

  localparam int PA_W = PAGE_W + 14;
  localparam logic [3:0] WAIT_LOAD = (MEM_WAIT > 0) ? 4'(MEM_WAIT - 1) : 4'd0;

  typedef enum logic [1:0] {HOLD, DL, RUN} state_t;

  state_t            state, state_nxt;
  logic [7:0]        hold_cnt, hold_nxt;
  logic [PAGE_W-1:0] page [4];
  logic [3:0]        wait_cnt;
  logic              active, done;

  logic dl_req, cpu_en, access, start, io_cyc, pg_hit, rom_hit, wr_prot;

  assign dl_req  = ioctl_download && (ioctl_index == 8'(DL_INDEX));
  assign cpu_en  = !reset && (state != DL);
  assign access  = cpu_en && !cpu_mreq_n && (!cpu_rd_n || !cpu_wr_n);
  assign start   = access && !active;
  assign io_cyc  = cpu_en && !cpu_iorq_n && cpu_m1_n;
  assign pg_hit  = io_cyc && (cpu_addr[7:2] == 6'b111100);
  assign rom_hit = int'(page[cpu_addr[15:14]]) < ROM_PAGES;

`ifdef WRITE_PROT_EN
  assign wr_prot = rom_hit;
  logic unused_bits;
  assign unused_bits = &{1'b0, ioctl_addr[24:PA_W]};
`else
  assign wr_prot = 1'b0;
  logic unused_bits;
  assign unused_bits = &{1'b0, ioctl_addr[24:PA_W], rom_hit};
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= HOLD;
      hold_cnt <= 8'(RST_HOLD);
      wait_cnt <= '0;
      active   <= 1'b0;
      done     <= 1'b0;
      for (int unsigned i = 0; i < 4; i++) page[i] <= PAGE_W'(i);
    end else begin
      state    <= state_nxt;
      hold_cnt <= hold_nxt;
      if (state == DL) begin
        wait_cnt <= '0;
        active   <= 1'b0;
        done     <= 1'b0;
      end else begin
        active <= access;
        if (start && (MEM_WAIT > 0)) wait_cnt <= WAIT_LOAD;
        else if (wait_cnt != '0)     wait_cnt <= wait_cnt - 4'd1;
        // done marks the write slot as consumed, even when protection blocked the strobe
        if (!access)                        done <= 1'b0;
        else if (!cpu_wr_n && cpu_wait_n)   done <= 1'b1;
        if (pg_hit && !cpu_wr_n) page[cpu_addr[1:0]] <= cpu_dout[PAGE_W-1:0];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    hold_nxt  = hold_cnt;
    cpu_reset = 1'b1;
    case (state)
      HOLD: begin
        if (dl_req) state_nxt = DL;
        else if (hold_cnt <= 8'd1) begin
          state_nxt = RUN;
          hold_nxt  = '0;
        end else hold_nxt = hold_cnt - 8'd1;
      end
      RUN: begin
        cpu_reset = 1'b0;
        if (dl_req) state_nxt = DL;
      end
      DL: begin
        if (!ioctl_download) begin
          state_nxt = HOLD;
          hold_nxt  = 8'(RST_HOLD);
        end
      end
      default: state_nxt = HOLD;
    endcase
  end

  assign cpu_wait_n = !(cpu_en && ((start && (MEM_WAIT > 0)) || (wait_cnt != '0)));

  always_comb begin
    mem_addr  = {page[cpu_addr[15:14]], cpu_addr[13:0]};
    mem_wdata = cpu_dout;
    mem_we    = access && !cpu_wr_n && cpu_wait_n && !done && !wr_prot;
    if (state == DL) begin
      mem_addr  = ioctl_addr[PA_W-1:0];
      mem_wdata = ioctl_dout;
      mem_we    = ioctl_wr && !reset;
    end
  end

  always_comb begin
    io_sel = '0;
    for (int unsigned i = 0; i < IO_DEVS; i++)
      if (io_cyc && (cpu_addr[7:3] == 5'(i))) io_sel[i] = 1'b1;
  end

  always_comb begin
    cpu_din = 8'hFF;
    if (cpu_en) begin
      if (!cpu_mreq_n)  cpu_din = mem_rdata;
      else if (pg_hit)  cpu_din = 8'(page[cpu_addr[1:0]]);
      else begin
        for (int unsigned i = 0; i < IO_DEVS; i++)
          if (io_sel[i]) cpu_din = io_rdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_smc_mem_mapper.sv
// Randomized self-checking bench for smc_mem_mapper against a page/bus-level reference model.
module tb_smc_mem_mapper;

  localparam int MEM_WAIT  = 3;
  localparam int RST_HOLD  = 16;
  localparam int ROM_PAGES = 1;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_dout, cpu_din;
  logic        cpu_mreq_n, cpu_iorq_n, cpu_rd_n, cpu_wr_n, cpu_m1_n;
  logic        cpu_wait_n, cpu_reset;
  logic        ioctl_download, ioctl_wr;
  logic [7:0]  ioctl_index, ioctl_dout;
  logic [24:0] ioctl_addr;
  logic [17:0] mem_addr;
  logic [7:0]  mem_wdata, mem_rdata;
  logic        mem_we;
  logic [7:0]  io_sel;
  logic [63:0] io_rdata;

  int errors = 0;
  int checks = 0;
  int pages[4];

  always #5 clk = ~clk;

  function automatic logic [7:0] hash(input logic [17:0] a);
    return a[7:0] ^ a[15:8] ^ {6'b0, a[17:16]} ^ 8'h5C;
  endfunction

  assign mem_rdata = hash(mem_addr);

  smc_mem_mapper #(.MEM_WAIT(MEM_WAIT), .RST_HOLD(RST_HOLD), .ROM_PAGES(ROM_PAGES)) dut (
    .clk(clk), .reset(reset), .cpu_addr(cpu_addr), .cpu_dout(cpu_dout), .cpu_din(cpu_din),
    .cpu_mreq_n(cpu_mreq_n), .cpu_iorq_n(cpu_iorq_n), .cpu_rd_n(cpu_rd_n), .cpu_wr_n(cpu_wr_n),
    .cpu_m1_n(cpu_m1_n), .cpu_wait_n(cpu_wait_n), .cpu_reset(cpu_reset),
    .ioctl_download(ioctl_download), .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr),
    .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .mem_rdata(mem_rdata), .io_sel(io_sel), .io_rdata(io_rdata)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic bus_idle();
    cpu_mreq_n = 1'b1; cpu_iorq_n = 1'b1; cpu_rd_n = 1'b1; cpu_wr_n = 1'b1; cpu_m1_n = 1'b1;
  endtask

  task automatic model_reset_pages();
    for (int i = 0; i < 4; i++) pages[i] = i;
  endtask

  task automatic io_op(input logic [7:0] port, input bit wr, input logic [7:0] d);
    int slot;
    logic [7:0] exp_sel, exp_din;
    @(negedge clk);
    cpu_addr = {8'($urandom), port};
    cpu_dout = d;
    cpu_iorq_n = 1'b0; cpu_m1_n = 1'b1; cpu_rd_n = wr; cpu_wr_n = !wr;
    #2;
    slot = int'(port) >> 3;
    exp_sel = (slot < 8) ? 8'(1 << slot) : 8'h00;
    check("io_sel", 32'(io_sel), 32'(exp_sel));
    check("io_wait", 32'(cpu_wait_n), 32'd1);
    if (!wr) begin
      if (port >= 8'hF0 && port <= 8'hF3) exp_din = 8'(pages[port[1:0]]);
      else if (slot < 8)                  exp_din = io_rdata[slot*8 +: 8];
      else                                exp_din = 8'hFF;
      check("io_din", 32'(cpu_din), 32'(exp_din));
    end else if (port >= 8'hF0 && port <= 8'hF3) begin
      pages[port[1:0]] = int'(d[3:0]);
    end
    @(negedge clk);
    bus_idle();
  endtask

  task automatic int_ack();
    @(negedge clk);
    cpu_addr = 16'($urandom);
    cpu_iorq_n = 1'b0; cpu_m1_n = 1'b0;
    #2;
    check("intack_sel", 32'(io_sel), 32'd0);
    check("intack_din", 32'(cpu_din), 32'hFF);
    @(negedge clk);
    bus_idle();
  endtask

  task automatic mem_op(input logic [15:0] a, input bit wr, input logic [7:0] d);
    logic [17:0] exp_a;
    bit prot, released;
    int waits, we_n, we_at;
    exp_a = {4'(pages[a[15:14]]), a[13:0]};
    prot = 1'b0;
`ifdef WRITE_PROT_EN
    prot = pages[a[15:14]] < ROM_PAGES;
`endif
    @(negedge clk);
    cpu_addr = a; cpu_dout = d;
    cpu_mreq_n = 1'b0; cpu_m1_n = 1'b1; cpu_rd_n = wr; cpu_wr_n = !wr;
    waits = 0; we_n = 0; we_at = 0; released = 1'b0;
    for (int c = 1; c <= 20 && !released; c++) begin
      #2;
      if (mem_we) begin
        we_n++; we_at = c;
        check("mem_we_addr", 32'(mem_addr), 32'(exp_a));
        check("mem_wdata", 32'(mem_wdata), 32'(d));
      end
      if (!cpu_wait_n) waits++;
      else begin
        released = 1'b1;
        check("mem_addr", 32'(mem_addr), 32'(exp_a));
        if (!wr) check("mem_din", 32'(cpu_din), 32'(hash(exp_a)));
      end
      @(negedge clk);
    end
    // strobes held one extra cycle after release: no second write strobe allowed
    #2;
    if (mem_we) we_n++;
    check("mem_released", 32'(released), 32'd1);
    check("mem_waits", 32'(waits), 32'(MEM_WAIT));
    check("mem_we_count", 32'(we_n), (wr && !prot) ? 32'd1 : 32'd0);
    if (wr && !prot) check("mem_we_cycle", 32'(we_at), 32'(MEM_WAIT + 1));
    @(negedge clk);
    bus_idle();
  endtask

  task automatic dl_write(input logic [24:0] a, input logic [7:0] d);
    @(negedge clk);
    ioctl_wr = 1'b1; ioctl_addr = a; ioctl_dout = d;
    #2;
    check("dl_we", 32'(mem_we), 32'd1);
    check("dl_addr", 32'(mem_addr), 32'(a[17:0]));
    check("dl_wdata", 32'(mem_wdata), 32'(d));
    @(negedge clk);
    ioctl_wr = 1'b0;
    #2;
    check("dl_we_idle", 32'(mem_we), 32'd0);
    check("dl_no_wait", 32'(cpu_wait_n), 32'd1);
  endtask

  task automatic count_hold(input string tag, input int exp);
    int n;
    n = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      n++;
      if (!cpu_reset) break;
    end
    check(tag, 32'(n), 32'(exp));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus_idle();
    cpu_addr = '0; cpu_dout = '0;
    ioctl_download = 1'b0; ioctl_index = '0; ioctl_wr = 1'b0; ioctl_addr = '0; ioctl_dout = '0;
    io_rdata = {$urandom, $urandom};
    model_reset_pages();

    repeat (3) @(negedge clk);
    #2;
    check("rst_cpu_reset", 32'(cpu_reset), 32'd1);
    check("rst_wait_n", 32'(cpu_wait_n), 32'd1);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_io_sel", 32'(io_sel), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    count_hold("hold_after_reset", RST_HOLD);
    for (int i = 0; i < 4; i++) io_op(8'hF0 + 8'(i), 1'b0, 8'h00);

    // download: CPU strobes left active to show the bus is ignored
    @(negedge clk);
    ioctl_index = 8'd0; ioctl_download = 1'b1;
    @(negedge clk);
    check("dl_cpu_reset", 32'(cpu_reset), 32'd1);
    cpu_addr = 16'h1234; cpu_mreq_n = 1'b0; cpu_wr_n = 1'b0;
    dl_write(25'h0000000, 8'h3E);
    dl_write(25'h0004001, 8'hAA);
    for (int i = 0; i < 4; i++) dl_write(25'($urandom), 8'($urandom));
    bus_idle();
    @(negedge clk);
    ioctl_download = 1'b0;
    count_hold("hold_after_dl", RST_HOLD + 1);

    @(negedge clk);
    ioctl_index = 8'd5; ioctl_download = 1'b1;
    repeat (3) @(negedge clk);
    check("other_index_run", 32'(cpu_reset), 32'd0);
    ioctl_download = 1'b0; ioctl_index = 8'd0;

    io_op(8'hF2, 1'b1, 8'h07);
    mem_op(16'h8005, 1'b0, 8'h00);
    check("page2_model", 32'({4'(pages[2]), 14'h0005}), 32'h1C005);
    io_op(8'hF2, 1'b0, 8'h00);
    mem_op(16'hC010, 1'b1, 8'hC3);

    io_rdata[23:16] = 8'h5A;
    io_op(8'h12, 1'b0, 8'h00);
    int_ack();
    io_op(8'hF5, 1'b0, 8'h00);
    mem_op(16'h0100, 1'b1, 8'h55);

    for (int it = 0; it < 60; it++) begin
      case ($urandom_range(0, 4))
        0: io_op(8'hF0 + 8'($urandom_range(0, 3)), 1'b1, 8'($urandom));
        1: mem_op(16'($urandom), 1'b0, 8'h00);
        2: mem_op(16'($urandom), 1'b1, 8'($urandom));
        3: io_op(8'($urandom), 1'b0, 8'h00);
        default: begin io_rdata = {$urandom, $urandom}; int_ack(); end
      endcase
    end

    // asynchronous reset in the middle of a wait-stated write
    @(negedge clk);
    cpu_addr = 16'h4000; cpu_dout = 8'h99; cpu_mreq_n = 1'b0; cpu_wr_n = 1'b0;
    #2;
    check("pre_rst_wait", 32'(cpu_wait_n), 32'd0);
    reset = 1'b1;
    #1;
    check("midrst_wait_n", 32'(cpu_wait_n), 32'd1);
    check("midrst_cpu_reset", 32'(cpu_reset), 32'd1);
    check("midrst_mem_we", 32'(mem_we), 32'd0);
    @(negedge clk);
    #2;
    check("midrst_mem_we_hold", 32'(mem_we), 32'd0);
    bus_idle();
    model_reset_pages();
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) io_op(8'hF0 + 8'(i), 1'b0, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/smc_mem_mapper.md
Name: smc_mem_mapper

Overview:
Parametrised memory/IO mapper for the SMC-777 core. It sits between the tv80e CPU bus and a single unified physical RAM that also holds the downloaded ROM image.
- Replaces fixed ROM/RAM chip-selects with four 16 KB page registers.
- Decodes IO devices, inserts programmable memory wait states, and owns the ioctl download path and the CPU reset hold.

Parameters:
PAGE_W, 4, physical page number width; physical address width is PAGE_W+14.
IO_DEVS, 8, number of 8-port IO device slots; range 1..30.
MEM_WAIT, 1, wait cycles inserted per memory access; 0..15.
RST_HOLD, 16, cycles CPU reset is held after reset release or download end; 1..255.
DL_INDEX, 0, ioctl_index value that targets this mapper.
ROM_PAGES, 1, physical pages 0..ROM_PAGES-1 that hold the ROM image.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
cpu_addr  in  16  CPU address
cpu_dout  in  8  CPU write data
cpu_din  out  8  CPU read data
cpu_mreq_n, cpu_iorq_n, cpu_rd_n, cpu_wr_n, cpu_m1_n  in  1 each  CPU strobes
cpu_wait_n  out  1  wait request to CPU
cpu_reset  out  1  active-high CPU/peripheral reset
ioctl_download  in  1  download active
ioctl_index  in  8  download target
ioctl_wr  in  1  download byte strobe
ioctl_addr  in  25  download byte address
ioctl_dout  in  8  download byte
mem_addr  out  PAGE_W+14  physical address
mem_wdata  out  8  physical write data
mem_we  out  1  one-cycle write strobe
mem_rdata  in  8  physical read data (combinational)
io_sel  out  IO_DEVS  one-hot device select
io_rdata  in  8*IO_DEVS  device read data, slot i at bits [8i+7:8i]

Behaviour:
- Reset values:
  - page[n] = n for n = 0..3.
  - cpu_wait_n = 1, cpu_reset = 1, mem_we = 0, io_sel = 0.
  - Hold counter = RST_HOLD, wait counter = 0.
- Reset hold FSM, states HOLD, DL, RUN:
  - HOLD: cpu_reset = 1; counter decrements each clk; at 0 go to RUN.
  - RUN: cpu_reset = 0; when ioctl_download & ioctl_index == DL_INDEX go to DL.
  - DL: cpu_reset = 1; when ioctl_download falls, reload the counter and go to HOLD.
  - A download starting while in HOLD goes to DL immediately.
- Download write path (DL state):
  - Each ioctl_wr cycle: mem_addr = ioctl_addr[PAGE_W+13:0], mem_wdata = ioctl_dout, mem_we = 1 for that cycle.
  - CPU bus is ignored in DL.
- Address translation: mem_addr = {page[cpu_addr[15:14]], cpu_addr[13:0]} whenever the state is not DL.
- Page registers:
  - IO ports 0xF0–0xF3 (cpu_addr[7:0]), iorq & ~m1.
  - Write: page[addr[1:0]] <= cpu_dout[PAGE_W-1:0].
  - Read: returns the page number zero-extended to 8 bits.
  - A page-register write takes effect on the next access.
- Memory access:
  - An access is mreq_n = 0 & (rd_n = 0 | wr_n = 0); it starts on the first cycle it is true.
  - Start cycle: cpu_wait_n = 0 combinationally when MEM_WAIT > 0, and the wait counter loads MEM_WAIT-1.
  - cpu_wait_n stays low while the counter is nonzero, giving exactly MEM_WAIT low cycles. MEM_WAIT = 0 never asserts wait.
  - Write: mem_we pulses once, on the first access cycle with cpu_wait_n = 1. A done flag suppresses repeats until the access ends.
  - mem_wdata = cpu_dout.
- IO decode:
  - iorq & ~m1 & cpu_addr[7:3] == i, for i < IO_DEVS, asserts io_sel[i].
  - Ports 0xF0–0xF7 never select a device.
  - IO cycles insert no wait states.
- cpu_din mux:
  - mreq: mem_rdata.
  - Page-register read: page value.
  - io_sel[i]: slot i data.
  - Interrupt acknowledge (iorq & m1) and unmapped reads: 0xFF.
- Asynchronous reset mid-access or mid-download: abort immediately, restore reset values; no mem_we after reset asserts.

Optional Feature:
WRITE_PROT_EN
- Defined: CPU writes to physical pages < ROM_PAGES are suppressed (no mem_we); wait timing is unchanged. Download writes are never suppressed.
- Undefined: all pages are CPU-writable.

Test Plan:
1. Reset release, no download -> cpu_reset high for exactly RST_HOLD = 16 cycles, then 0; pages = 0,1,2,3.
2. Download index 0, write 0x3E to ioctl_addr 0x0000 and 0xAA to 0x4001, then drop download -> mem_we pulses at addresses 0x00000 and 0x04001; cpu_reset held through the download plus 16 cycles.
3. OUT (0xF2), 0x07, then read 0x8005 -> mem_addr = 0x1C005; IN (0xF2) returns 0x07.
4. MEM_WAIT = 3, memory write to 0xC010 -> cpu_wait_n low exactly 3 cycles, single mem_we pulse on cycle 4 of the access.
5. IN (0x12) with io_rdata slot 2 = 0x5A -> io_sel = 8'b0000_0100, cpu_din = 0x5A. Interrupt acknowledge -> io_sel = 0, cpu_din = 0xFF.
6. With WRITE_PROT_EN, CPU write to 0x0100 -> no mem_we. Reset asserted mid-wait -> cpu_wait_n = 1 and cpu_reset = 1 immediately.
